// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the load/store front end.
// Size codes, FSM states and the byte-lane merge/extract functions.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_t;

    // Illegal size code counts as a bad access just like misalignment
    function automatic logic isMisaligned(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = (lane != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] storeMerge(
        input logic [31:0] oldWord,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] w;
        w = oldWord;
        case (size)
            SIZE_BYTE: w[{lane, 3'b000} +: 8] = wdata[7:0];
            SIZE_HALF: w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default:   w = wdata;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] loadExtract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        isUnsigned
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SIZE_BYTE: r = isUnsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SIZE_HALF: r = isUnsigned ? {16'b0, h} : {{16{h[15]}}, h};
            SIZE_WORD: r = word;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering between memory words and requests.
// Produces the read-modify-write word and the extended load value.
module mem_byte_lane
    import mem_access_pkg::*;
(
    input  logic [31:0] oldWord,
    input  logic [31:0] storeData,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        isUnsigned,
    output logic [31:0] mergedWord,
    output logic [31:0] loadValue
);

    // Both results depend only on the word currently read from memory
    always_comb begin
        mergedWord = storeMerge(oldWord, storeData, size, lane);
        loadValue  = loadExtract(oldWord, size, lane, isUnsigned);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the word-addressed asynchronous DataMemory.
// Optional range check: define MEM_ACCESS_BOUNDS_CHECK_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [1:0]        reqSize,
    input  logic              reqUnsigned,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [31:0]       reqWdata,
    output logic [31:0]       memAddr,
    output logic [31:0]       memData,
    output logic              memReadFlag,
    output logic              memWriteFlag,
    input  logic [31:0]       memRdata,
    output logic              respValid,
    output logic              respErr,
    output logic [31:0]       loadData
);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    localparam bit boundsEn = 1'b1;
`else
    localparam bit boundsEn = 1'b0;
`endif

    state_t      state;
    state_t      nextState;
    logic        rWrite;
    logic        rUnsigned;
    logic [1:0]  rSize;
    logic [1:0]  rLane;
    logic [31:0] rWdata;
    logic        accept;
    logic        beyondMem;
    logic        reqErr;
    logic [31:0] mergedWord;
    logic [31:0] loadValue;

    assign beyondMem = (reqAddr >> 2) >= ADDR_W'(MEM_WORDS);
    assign reqErr    = isMisaligned(reqSize, reqAddr[1:0])
                     | (boundsEn & beyondMem);
    assign accept    = reqValid & reqReady;

    mem_byte_lane uLane (
        .oldWord    (memRdata),
        .storeData  (rWdata),
        .size       (rSize),
        .lane       (rLane),
        .isUnsigned (rUnsigned),
        .mergedWord (mergedWord),
        .loadValue  (loadValue)
    );

    // State register; reset drops the memory enables without a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= nextState;
    end

    // Next state plus enables decoded purely from the state register
    always_comb begin
        nextState    = state;
        reqReady     = 1'b0;
        memReadFlag  = 1'b0;
        memWriteFlag = 1'b0;
        respValid    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                reqReady = 1'b1;
                if (accept) begin
                    if (reqErr)
                        nextState = ST_RESP;
                    else if (!reqWrite || reqSize != SIZE_WORD)
                        nextState = ST_RD;
                    else
                        nextState = ST_WR;
                end
            end
            ST_RD: begin
                memReadFlag = 1'b1;
                nextState   = rWrite ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                memWriteFlag = 1'b1;
                nextState    = ST_RESP;
            end
            ST_RESP: begin
                respValid = 1'b1;
                nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // Request capture, RMW word build and response result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rWrite    <= 1'b0;
            rUnsigned <= 1'b0;
            rSize     <= SIZE_BYTE;
            rLane     <= 2'b00;
            rWdata    <= '0;
            memAddr   <= '0;
            memData   <= '0;
            respErr   <= 1'b0;
            loadData  <= '0;
        end else begin
            if (accept) begin
                rWrite    <= reqWrite;
                rUnsigned <= reqUnsigned;
                rSize     <= reqSize;
                rLane     <= reqAddr[1:0];
                rWdata    <= reqWdata;
                memAddr   <= 32'(reqAddr >> 2);
                if (reqWrite) memData <= reqWdata;
                if (reqErr) begin
                    respErr  <= 1'b1;
                    loadData <= '0;
                end
            end
            if (state == ST_RD) begin
                if (rWrite) begin
                    memData <= mergedWord;
                end else begin
                    respErr  <= 1'b0;
                    loadData <= loadValue;
                end
            end
            if (state == ST_WR) begin
                respErr  <= 1'b0;
                loadData <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a word memory model.
// Directed table, reset-during-write sequence, then random traffic.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic        memReadFlag;
    logic        memWriteFlag;
    logic [31:0] memRdata;
    logic        respValid;
    logic        respErr;
    logic [31:0] loadData;
    logic        memClear;

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] mem    [0:63];
    logic [31:0] refMem [0:63];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .MEM_WORDS(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqWrite     (reqWrite),
        .reqSize      (reqSize),
        .reqUnsigned  (reqUnsigned),
        .reqAddr      (reqAddr),
        .reqWdata     (reqWdata),
        .memAddr      (memAddr),
        .memData      (memData),
        .memReadFlag  (memReadFlag),
        .memWriteFlag (memWriteFlag),
        .memRdata     (memRdata),
        .respValid    (respValid),
        .respErr      (respErr),
        .loadData     (loadData)
    );

    assign memRdata = mem[memAddr[5:0]];

    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (memWriteFlag) begin
            mem[memAddr[5:0]] <= memData;
        end
    end

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        int          lat;
        logic [31:0] ld;
        logic [31:0] word;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference: byte-addressed semantics via shifts and masks
    task automatic refExec(input logic w, input logic [1:0] sz,
                           input logic u, input logic [31:0] a,
                           input logic [31:0] d, output logic e,
                           output int lat, output logic [31:0] ld,
                           output logic [31:0] nw);
        int unsigned sh, idx, v, mask;
        sh  = 8 * (a % 4);
        idx = a / 4;
        e   = (sz == 3) || (sz == 1 && a % 2 != 0)
           || (sz == 2 && a % 4 != 0);
        ld  = 0;
        nw  = 0;
        lat = 1;
        if (!e && !w) begin
            lat = 2;
            v = refMem[idx] >> sh;
            if (sz == 0) begin
                v = v % 256;
                if (!u) v = (v ^ 32'h80) - 32'h80;
            end else if (sz == 1) begin
                v = v % 65536;
                if (!u) v = (v ^ 32'h8000) - 32'h8000;
            end
            ld = v;
        end else if (!e) begin
            lat  = (sz == 2) ? 2 : 3;
            mask = (sz == 0) ? (32'hFF << sh)
                 : (sz == 1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
            nw = (refMem[idx] & ~mask) | ((d << sh) & mask);
            refMem[idx] = nw;
        end
    endtask

    task automatic runReq(input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a,
                          input logic [31:0] d, input logic expE,
                          input int expLat, input logic [31:0] expLd,
                          input logic [31:0] expWord);
        int          lat;
        logic        sawRd, sawWr, done;
        logic [31:0] wrWord, seenAddr, gotLd;
        logic        gotE;
        lat = 0; sawRd = 0; sawWr = 0; done = 0;
        wrWord = 0; seenAddr = 0; gotLd = 0; gotE = 0;
        @(negedge clk);
        for (int i = 0; i < 10 && !reqReady; i++) @(negedge clk);
        chk("ready", 32'(reqReady), 32'd1);
        reqValid = 1; reqWrite = w; reqSize = sz; reqUnsigned = u;
        reqAddr = a; reqWdata = d;
        @(posedge clk);
        #1 reqValid = 0;
        reqWdata = ~d;
        for (int n = 1; n <= 8 && !done; n++) begin
            @(negedge clk);
            if (memReadFlag) begin
                sawRd = 1; seenAddr = memAddr;
            end
            if (memWriteFlag) begin
                sawWr = 1; wrWord = memData; seenAddr = memAddr;
            end
            if (respValid) begin
                done = 1; lat = n; gotE = respErr; gotLd = loadData;
            end
        end
        chk("latency", 32'(lat), 32'(expLat));
        chk("respErr", 32'(gotE), 32'(expE));
        chk("loadData", gotLd, expLd);
        chk("readEn", 32'(sawRd), 32'(!expE && (!w || sz != 2)));
        chk("writeEn", 32'(sawWr), 32'(!expE && w));
        if (!expE) chk("memAddr", seenAddr, a >> 2);
        if (!expE && w) chk("memData", wrWord, expWord);
        @(negedge clk);
        chk("pulse", 32'(respValid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        e, seen, pulsed;
        int          lat;
        logic [31:0] ld, nw, a, d;
        logic        w, u;
        logic [1:0]  sz;

        tbl[0]  = '{1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 2, 32'h0, 32'hDEADBEEF};
        tbl[1]  = '{0, 2, 0, 32'h10, 32'h0, 0, 2, 32'hDEADBEEF, 32'h0};
        tbl[2]  = '{1, 0, 0, 32'h12, 32'h55, 0, 3, 32'h0, 32'hDE55BEEF};
        tbl[3]  = '{0, 2, 0, 32'h10, 32'h0, 0, 2, 32'hDE55BEEF, 32'h0};
        tbl[4]  = '{0, 0, 0, 32'h13, 32'h0, 0, 2, 32'hFFFFFFDE, 32'h0};
        tbl[5]  = '{0, 0, 1, 32'h13, 32'h0, 0, 2, 32'h000000DE, 32'h0};
        tbl[6]  = '{0, 1, 1, 32'h10, 32'h0, 0, 2, 32'h0000BEEF, 32'h0};
        tbl[7]  = '{0, 1, 0, 32'h10, 32'h0, 0, 2, 32'hFFFFBEEF, 32'h0};
        tbl[8]  = '{0, 2, 0, 32'h11, 32'h0, 1, 1, 32'h0, 32'h0};
        tbl[9]  = '{1, 1, 0, 32'h13, 32'h1234, 1, 1, 32'h0, 32'h0};
        tbl[10] = '{0, 3, 0, 32'h0, 32'h0, 1, 1, 32'h0, 32'h0};
        tbl[11] = '{1, 1, 0, 32'h12, 32'h1234, 0, 3, 32'h0, 32'h1234BEEF};
        tbl[12] = '{0, 1, 0, 32'h12, 32'h0, 0, 2, 32'h00001234, 32'h0};
        tbl[13] = '{0, 0, 0, 32'h11, 32'h0, 0, 2, 32'hFFFFFFBE, 32'h0};
        tbl[14] = '{0, 0, 1, 32'h11, 32'h0, 0, 2, 32'h000000BE, 32'h0};

        for (int i = 0; i < 64; i++) refMem[i] = '0;
        reset = 1; memClear = 1;
        reqValid = 0; reqWrite = 0; reqSize = 0; reqUnsigned = 0;
        reqAddr = 0; reqWdata = 0;
        repeat (3) @(negedge clk);

        chk("rst_reqReady", 32'(reqReady), 32'd1);
        chk("rst_respValid", 32'(respValid), 32'd0);
        chk("rst_respErr", 32'(respErr), 32'd0);
        chk("rst_readEn", 32'(memReadFlag), 32'd0);
        chk("rst_writeEn", 32'(memWriteFlag), 32'd0);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_memData", memData, 32'd0);
        chk("rst_loadData", loadData, 32'd0);
        reset = 0; memClear = 0;

        for (int i = 0; i < 15; i++) begin
            refExec(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].d,
                    e, lat, ld, nw);
            runReq(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].d,
                   tbl[i].e, tbl[i].lat, tbl[i].ld, tbl[i].word);
        end

        repeat (2) @(negedge clk);
        chk("hold_loadData", loadData, 32'h000000BE);
        chk("hold_respErr", 32'(respErr), 32'd0);

        // Reset asserted mid-WR of a byte store
        @(negedge clk);
        reqValid = 1; reqWrite = 1; reqSize = 0; reqUnsigned = 0;
        reqAddr = 32'h14; reqWdata = 32'hAA;
        @(posedge clk);
        #1 reqValid = 0;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (memWriteFlag) seen = 1;
        end
        chk("rst_mid_reach_wr", 32'(seen), 32'd1);
        #2 reset = 1;
        #1 chk("rst_mid_wr_drop", 32'(memWriteFlag), 32'd0);
        pulsed = 0;
        repeat (2) begin
            @(negedge clk);
            if (respValid) pulsed = 1;
        end
        reset = 0;
        repeat (3) begin
            @(negedge clk);
            if (respValid) pulsed = 1;
        end
        chk("rst_mid_no_resp", 32'(pulsed), 32'd0);
        chk("rst_mid_ready", 32'(reqReady), 32'd1);
        refMem[5] = mem[5];
        refExec(0, 2, 0, 32'h10, 0, e, lat, ld, nw);
        runReq(0, 2, 0, 32'h10, 0, e, lat, ld, nw);

        // Random traffic against the reference model
        for (int k = 0; k < 300; k++) begin
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3
                 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0)
                a = a & ~((sz == 2) ? 32'd3 : (sz == 1) ? 32'd1 : 32'd0);
            d  = $urandom;
            refExec(w, sz, u, a, d, e, lat, ld, nw);
            runReq(w, sz, u, a, d, e, lat, ld, nw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end sitting between the EX-stage result and the word-addressed, asynchronous DataMemory.
- Accepts one byte, halfword or word request at a time and converts byte addresses to word indices.
- Performs read-modify-write for sub-word stores, since memory writes whole words only.
- Sign- or zero-extends load results and flags misaligned or illegal accesses.
- Returns a one-cycle response pulse to the pipeline control.

Parameters:
- ADDR_W, 32, width of the byte address from EX.
- MEM_WORDS, 32, number of 32-bit words in DataMemory; used only by the optional bounds check.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- reqValid  in  1  request present.
- reqReady  out  1  unit idle and able to accept a request.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  00 byte, 01 half, 10 word, 11 illegal.
- reqUnsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
- reqAddr  in  ADDR_W  byte address.
- reqWdata  in  32  store data, right-aligned.
- memAddr  out  32  word index, equal to reqAddr>>2.
- memData  out  32  write word to memory.
- memReadFlag  out  1  memory read enable.
- memWriteFlag  out  1  memory write enable.
- memRdata  in  32  memory read word (asynchronous).
- respValid  out  1  one-cycle completion pulse.
- respErr  out  1  request rejected, valid with respValid.
- loadData  out  32  extended load result, valid with respValid.

Behaviour:
- Clock, reset and single clock domain are fixed: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values:
  - state = IDLE, reqReady = 1.
  - memAddr, memData, memReadFlag, memWriteFlag, respValid, respErr, loadData all 0.
- Handshake:
  - A request is accepted at a rising edge with reqValid & reqReady.
  - All request fields are registered at acceptance.
  - reqReady = 1 only in IDLE.
- FSM states: IDLE, RD, WR, RESP.
- Transitions from IDLE on accept:
  - Error -> RESP.
  - Load -> RD.
  - Word store -> WR.
  - Sub-word store -> RD.
- Further transitions:
  - RD (load) -> RESP.
  - RD (store) -> WR.
  - WR -> RESP.
  - RESP -> IDLE.
- State outputs:
  - RD: memReadFlag = 1; memRdata is captured at the end of the cycle.
  - WR: memWriteFlag = 1.
- Memory-side signal integrity:
  - memAddr and memData come from registers and are stable for the whole RD/WR cycle.
  - memWriteFlag is driven from a registered state decode only, so the level-sensitive memory sees no glitches.
- Latency, counted in cycles after the accept edge; respValid is high in the listed cycle:
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
  - Error: 1.
- Byte lanes are little-endian; lane = reqAddr[1:0].
  - Byte store: replace bits [8*lane+7 : 8*lane].
  - Half store: replace [15:0] when reqAddr[1] = 0, otherwise [31:16].
  - Loads extract the same lanes, then sign- or zero-extend to 32 bits.
- Errors:
  - Error conditions: reqSize = 11; half with reqAddr[0] != 0; word with reqAddr[1:0] != 0.
  - An error produces no memory access, respErr = 1 and loadData = 0.
- Response outputs:
  - loadData and respErr are held until the next respValid.
  - loadData is 0 for stores.
- reqValid arriving outside IDLE is ignored; the upstream stage holds it until reqReady.
- Reset asserted mid-operation:
  - State returns to IDLE immediately and all memory enables drop asynchronously.
  - No respValid is produced.
  - A WR cycle may already have committed; this is accepted.

Optional Feature:
- Macro: MEM_ACCESS_BOUNDS_CHECK_EN.
- Defined:
  - reqAddr[ADDR_W-1:2] >= MEM_WORDS is treated as an error, with the same timing and outputs as a misalignment error.
  - No memory enables are driven for such a request.
- Undefined:
  - No range check is made; memAddr = reqAddr>>2 is passed through unchanged.

Decomposition:
- Package mem_access_pkg holds:
  - Size constants SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - The state enum, ST_IDLE/ST_RD/ST_WR/ST_RESP.
  - Functions for misalignment test, store merge and load extract.
- One natural sub-module, mem_byte_lane: purely combinational.
  - Inputs: old word, store data, size, lane, unsigned.
  - Outputs: merged word and extended load value.

Test Plan:
- Word store, then word load: SW addr 0x10 data 0xDEADBEEF, then LW 0x10.
  - Memory index 4 is written in WR.
  - Load gives loadData = 0xDEADBEEF with respValid 2 cycles after accept.
- Byte store merge: with word 4 = 0xDEADBEEF, SB addr 0x12 data 0x55.
  - Sequence is RD, then WR with memData = 0xDE55BEEF.
  - respValid 3 cycles after accept.
- Sign extension: LB 0x13 on 0xDE55BEEF gives 0xFFFFFFDE; LBU gives 0x000000DE; LHU 0x10 gives 0x0000BEEF.
- Misalignment: LW 0x11 and SH 0x13.
  - respErr = 1, loadData = 0, respValid 1 cycle after accept.
  - memReadFlag and memWriteFlag never assert.
- Reset during the WR cycle of an SB.
  - memWriteFlag falls without waiting for a clock edge, and respValid never pulses.
  - After release, reqReady = 1 and the next LW completes normally.
- With MEM_ACCESS_BOUNDS_CHECK_EN defined: LW 0x80 (index 32) returns respErr = 1 with no memory access.
  - With the macro undefined, the same request gives memAddr = 32 and memReadFlag = 1.
